spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, meaning active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2).
REQ-004 SHALL have port i_clk  input  1  sole clock; one clock, all state in this domain.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_mosi_data  input  24  received SPI word, [23:16] opcode, [15:0] payload.
REQ-007 SHALL have port i_mosi_en_pls  input  1  one-clock valid pulse for i_mosi_data.
REQ-008 SHALL have port o_fb_addr  output  17  frame-buffer word address, y*H_ACTIVE+x.
REQ-009 SHALL have port o_fb_data  output  16  RGB565 pixel.
REQ-010 SHALL have port o_fb_we  output  1  write request, held until accepted.
REQ-011 SHALL have port i_fb_ready  input  1  frame-buffer accepts write on a clock where o_fb_we and i_fb_ready are both high.
REQ-012 SHALL have port o_backlight  output  8  backlight PWM duty.
REQ-013 SHALL have port o_disp_en  output  1  display enable.
REQ-014 SHALL have port o_status  output  3  sticky flags {unknown_opcode, range_err, overflow}.

Function
REQ-015 SHALL push i_mosi_data into the FIFO on each clock with i_mosi_en_pls high and FIFO not full.
REQ-016 SHALL drop a word pushed while FIFO is full and set overflow, even if a pop occurs the same clock.
REQ-017 SHALL support simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-018 SHALL run FSM IDLE -> DECODE -> (IDLE | WRITE): IDLE pops and latches the head word when FIFO is not empty; DECODE executes it; WRITE holds o_fb_we until i_fb_ready, then returns to IDLE.
REQ-019 SHALL assert o_fb_we on the 2nd rising edge after the push edge when FSM is IDLE and FIFO is empty.
REQ-020 SHALL execute opcode 0x01 SET_X: x <= payload if payload < H_ACTIVE, else x unchanged and set range_err.
REQ-021 SHALL execute opcode 0x02 SET_Y: y <= payload if payload < V_ACTIVE, else y unchanged and set range_err.
REQ-022 SHALL execute opcode 0x03 WRITE_PIXEL: o_fb_addr <= y*H_ACTIVE+x, o_fb_data <= payload, o_fb_we <= 1, enter WRITE.
REQ-023 SHALL advance the cursor after each accepted write: x+1; at x=H_ACTIVE-1, x <= 0 and y+1; at y=V_ACTIVE-1 as well, y <= 0.
REQ-024 SHALL keep o_fb_addr and o_fb_data stable while o_fb_we is high and i_fb_ready is low.
REQ-025 SHALL deassert o_fb_we on the clock after acceptance, and SHALL NOT assert it back-to-back: minimum 3 clocks per pixel.
REQ-026 SHALL execute opcode 0x10 SET_BL: o_backlight <= payload[7:0].
REQ-027 SHALL execute opcode 0x11 DISP: o_disp_en <= payload[0].
REQ-028 SHALL execute opcode 0x1F CLR_STATUS: o_status <= 0; a flag event in the same clock wins over the clear.
REQ-029 SHALL ignore any other opcode and set unknown_opcode.
REQ-030 SHALL compute the address as a registered product, exact for 17 bits, with no truncation at (479,271) = 130559.

Reset
REQ-031 SHALL, on i_rst_n low, asynchronously set FSM=IDLE, FIFO empty, x=y=0, o_fb_addr=0, o_fb_data=0, o_fb_we=0, o_backlight=0, o_disp_en=0, o_status=0.
REQ-032 SHALL abandon a pending write on reset mid-WRITE; the pixel is lost and the cursor is not advanced.

Structure
REQ-033 SHALL place opcode constants, FSM state encodings and status bit indices in shared package lcd_ctrl_pkg.
REQ-034 SHALL instantiate one sub-module sync_fifo (width 24, depth FIFO_DEPTH, full/empty outputs, same clock and reset).

Verification
REQ-035 SHALL verify: SET_X 0x0005, SET_Y 0x0002, WRITE_PIXEL 0xF800 with i_fb_ready=1 -> one write, addr 965, data 0xF800, cursor x=6.
REQ-036 SHALL verify: SET_X 479, SET_Y 271, WRITE_PIXEL twice -> addrs 130559 then 0; cursor wraps to (1,0).
REQ-037 SHALL verify: i_fb_ready low for 10 clocks during a write -> o_fb_we/addr/data stable for 10 clocks, exactly one accept.
REQ-038 SHALL verify: 6 pulses while i_fb_ready=0 -> 1 in WRITE, 4 queued, 1 dropped, overflow=1; after release 5 pixels are written in order.
REQ-039 SHALL verify: SET_X 480 -> x unchanged, range_err=1; opcode 0x7E -> unknown_opcode=1; CLR_STATUS -> o_status=0.
REQ-040 SHALL verify: i_rst_n low mid-WRITE -> o_fb_we=0 immediately, all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the SPI command to LCD frame-buffer controller:
// word layout, opcodes, FSM state encoding and status flag positions.
package lcd_ctrl_pkg;

    localparam int WORD_W = 24;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 16;

    localparam logic [7:0] OP_SET_X       = 8'h01;
    localparam logic [7:0] OP_SET_Y       = 8'h02;
    localparam logic [7:0] OP_WRITE_PIXEL = 8'h03;
    localparam logic [7:0] OP_SET_BL      = 8'h10;
    localparam logic [7:0] OP_DISP        = 8'h11;
    localparam logic [7:0] OP_CLR_STATUS  = 8'h1F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    localparam int STAT_OVERFLOW   = 0;
    localparam int STAT_RANGE_ERR  = 1;
    localparam int STAT_UNKNOWN_OP = 2;
    localparam int STAT_W          = 3;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] payload;
    } cmd_t;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Command-in / frame-buffer-write bus of spi_cmd_ctrl. The controller side
// uses the master modport, the SPI receiver and frame buffer the slave one.
interface spi_cmd_ctrl_if;
    import lcd_ctrl_pkg::*;

    logic [WORD_W-1:0] i_mosi_data;
    logic              i_mosi_en_pls;
    logic [ADDR_W-1:0] o_fb_addr;
    logic [PIX_W-1:0]  o_fb_data;
    logic              o_fb_we;
    logic              i_fb_ready;

    modport master (
        input  i_mosi_data, i_mosi_en_pls, i_fb_ready,
        output o_fb_addr, o_fb_data, o_fb_we
    );

    modport slave (
        output i_mosi_data, i_mosi_en_pls, i_fb_ready,
        input  o_fb_addr, o_fb_data, o_fb_we
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. DEPTH must be a power of
// two of at least 2; a push while full is dropped even if a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count alone define validity,
    // which keeps the array as plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes queued 24-bit SPI command words into cursor moves, frame-buffer
// pixel writes (valid/ready handshake) and display control registers.
module spi_cmd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    spi_cmd_ctrl_if.master    bus,
    output logic [7:0]        o_backlight,
    output logic              o_disp_en,
    output logic [STAT_W-1:0] o_status
);

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    state_e             state;
    cmd_t               cmd;
    cmd_t               fifo_head;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               x_in_range;
    logic               y_in_range;
    logic               clr_status;
    logic [STAT_W-1:0]  flag_evt;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (bus.i_mosi_en_pls),
        .wr_data (bus.i_mosi_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign x_in_range = 32'(cmd.payload) < 32'(H_ACTIVE);
    assign y_in_range = 32'(cmd.payload) < 32'(V_ACTIVE);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        flag_evt                = '0;
        clr_status              = 1'b0;
        flag_evt[STAT_OVERFLOW] = bus.i_mosi_en_pls && fifo_full;
        if (state == ST_DECODE) begin
            case (cmd.op)
                OP_SET_X:       flag_evt[STAT_RANGE_ERR] = !x_in_range;
                OP_SET_Y:       flag_evt[STAT_RANGE_ERR] = !y_in_range;
                OP_WRITE_PIXEL,
                OP_SET_BL,
                OP_DISP:        begin end
                OP_CLR_STATUS:  clr_status = 1'b1;
                default:        flag_evt[STAT_UNKNOWN_OP] = 1'b1;
            endcase
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cmd           <= '0;
            x             <= '0;
            y             <= '0;
            bus.o_fb_addr <= '0;
            bus.o_fb_data <= '0;
            bus.o_fb_we   <= 1'b0;
            o_backlight   <= '0;
            o_disp_en     <= 1'b0;
            o_status      <= '0;
        end else begin
            // Flag events are OR-ed after the clear so they survive it.
            o_status <= (clr_status ? '0 : o_status) | flag_evt;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd   <= fifo_head;
                        state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    state <= ST_IDLE;
                    case (cmd.op)
                        OP_SET_X: if (x_in_range) x <= X_W'(cmd.payload);
                        OP_SET_Y: if (y_in_range) y <= Y_W'(cmd.payload);
                        OP_WRITE_PIXEL: begin
                            bus.o_fb_addr <= ADDR_W'(32'(y) * 32'(H_ACTIVE) + 32'(x));
                            bus.o_fb_data <= cmd.payload;
                            bus.o_fb_we   <= 1'b1;
                            state         <= ST_WRITE;
                        end
                        OP_SET_BL: o_backlight <= cmd.payload[7:0];
                        OP_DISP:   o_disp_en   <= cmd.payload[0];
                        default:   begin end
                    endcase
                end

                ST_WRITE: begin
                    // Address and data stay frozen until the frame buffer accepts.
                    if (bus.i_fb_ready) begin
                        bus.o_fb_we <= 1'b0;
                        state       <= ST_IDLE;
                        if (x == X_W'(H_ACTIVE - 1)) begin
                            x <= '0;
                            y <= (y == Y_W'(V_ACTIVE - 1)) ? '0 : y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: register vector table, directed
// multi-cycle sequences and randomized commands against a command-level model.
module tb_spi_cmd_ctrl;

    localparam int H = 480;
    localparam int V = 272;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bl;
    logic       disp;
    logic [2:0] status;
    logic       man_ready = 1'b0;
    logic       rand_ready = 1'b0;
    logic       rand_mode = 1'b0;

    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_backlight (bl),
        .o_disp_en   (disp),
        .o_status    (status)
    );

    always #5 clk = ~clk;

    assign bus.i_fb_ready = rand_mode ? rand_ready : man_ready;

    always @(posedge clk) begin
        #1;
        rand_ready = 1'($urandom_range(0, 1));
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t acc_log[$];
    int  n_exp_total = 0;

    // Command-level reference model state.
    int       mx = 0, my = 0, mbl = 0, mdisp = 0;
    logic [2:0] mstat = 3'b000;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] pl;
        logic [7:0]  bl;
        logic        disp;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mbl = 0; mdisp = 0; mstat = 3'b000;
    endtask

    task automatic model_apply(input logic [7:0] op, input logic [15:0] pl);
        wr_t w;
        case (op)
            8'h01: if (int'(pl) < H) mx = int'(pl); else mstat[1] = 1'b1;
            8'h02: if (int'(pl) < V) my = int'(pl); else mstat[1] = 1'b1;
            8'h03: begin
                w.addr = my * H + mx;
                w.data = int'(pl);
                exp_q.push_back(w);
                n_exp_total++;
                mx = mx + 1;
                if (mx == H) begin
                    mx = 0;
                    my = (my + 1) % V;
                end
            end
            8'h10: mbl = int'(pl) % 256;
            8'h11: mdisp = int'(pl) % 2;
            8'h1F: mstat = 3'b000;
            default: mstat[2] = 1'b1;
        endcase
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [15:0] pl);
        bus.i_mosi_data   = {op, pl};
        bus.i_mosi_en_pls = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mosi_en_pls = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [15:0] pl);
        model_apply(op, pl);
        send(op, pl);
    endtask

    task automatic wait_writes(input string name, input int budget);
        int k = 0;
        while (acc_log.size() < n_exp_total && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, acc_log.size(), n_exp_total);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_bl"}, bl, mbl);
        check({tag, "_disp"}, disp, mdisp);
        check({tag, "_status"}, status, mstat);
    endtask

    // A write is accepted at the next rising edge when both are high here.
    always @(negedge clk) begin
        wr_t a;
        wr_t e;
        if (rst_n && bus.o_fb_we && bus.i_fb_ready) begin
            a.addr = int'(bus.o_fb_addr);
            a.data = int'(bus.o_fb_data);
            acc_log.push_back(a);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: actual addr=%0d data=0x%0h required no write",
                         a.addr, a.data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", a.addr, e.addr);
                check("wr_data", a.data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int stable;
        logic [16:0] a0;
        logic [15:0] d0;

        vecs[0]  = '{8'h01, 16'h0007, 8'h00, 1'b0, 3'b000};
        vecs[1]  = '{8'h10, 16'h1234, 8'h34, 1'b0, 3'b000};
        vecs[2]  = '{8'h11, 16'h0001, 8'h34, 1'b1, 3'b000};
        vecs[3]  = '{8'h11, 16'hFFFE, 8'h34, 1'b0, 3'b000};
        vecs[4]  = '{8'h01, 16'h01E0, 8'h34, 1'b0, 3'b010};
        vecs[5]  = '{8'h7E, 16'h0000, 8'h34, 1'b0, 3'b110};
        vecs[6]  = '{8'h1F, 16'h0000, 8'h34, 1'b0, 3'b000};
        vecs[7]  = '{8'h02, 16'h0110, 8'h34, 1'b0, 3'b010};
        vecs[8]  = '{8'h02, 16'h010F, 8'h34, 1'b0, 3'b010};
        vecs[9]  = '{8'h1F, 16'h0000, 8'h34, 1'b0, 3'b000};
        vecs[10] = '{8'h10, 16'h00FF, 8'hFF, 1'b0, 3'b000};
        vecs[11] = '{8'h11, 16'h0001, 8'hFF, 1'b1, 3'b000};

        bus.i_mosi_data   = '0;
        bus.i_mosi_en_pls = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_we", bus.o_fb_we, 0);
        check("rst_addr", bus.o_fb_addr, 0);
        check("rst_data", bus.o_fb_data, 0);
        check("rst_bl", bl, 0);
        check("rst_disp", disp, 0);
        check("rst_status", status, 0);

        for (int i = 0; i < 12; i++) begin
            cmd(vecs[i].op, vecs[i].pl);
            ticks(3);
            check($sformatf("vec%0d_bl", i), bl, vecs[i].bl);
            check($sformatf("vec%0d_disp", i), disp, vecs[i].disp);
            check($sformatf("vec%0d_status", i), status, vecs[i].st);
        end

        // SET_X 480 was rejected, so x is still 7 on line 271.
        man_ready = 1'b1;
        cmd(8'h03, 16'hAAAA);
        wait_writes("x_unchanged_wait", 50);
        check("x_unchanged_addr", acc_log[acc_log.size()-1].addr, 130087);

        // Basic pixel at (5,2) and push-to-write latency.
        cmd(8'h01, 16'h0005);
        ticks(3);
        cmd(8'h02, 16'h0002);
        ticks(3);
        cmd(8'h03, 16'hF800);
        check("lat_push_edge_we", bus.o_fb_we, 0);
        ticks(1);
        check("lat_edge1_we", bus.o_fb_we, 0);
        ticks(1);
        check("lat_edge2_we", bus.o_fb_we, 1);
        check("pix_addr", bus.o_fb_addr, 965);
        check("pix_data", bus.o_fb_data, 16'hF800);
        wait_writes("pix_wait", 50);
        cmd(8'h03, 16'h001F);
        wait_writes("cursor_wait", 50);
        check("cursor_x6_addr", acc_log[acc_log.size()-1].addr, 966);

        // Last pixel of the frame and wrap to the origin.
        cmd(8'h01, 16'd479);
        ticks(3);
        cmd(8'h02, 16'd271);
        ticks(3);
        cmd(8'h03, 16'h1111);
        wait_writes("wrap_wait0", 50);
        check("wrap_addr_last", acc_log[acc_log.size()-1].addr, 130559);
        cmd(8'h03, 16'h2222);
        wait_writes("wrap_wait1", 50);
        check("wrap_addr_zero", acc_log[acc_log.size()-1].addr, 0);
        cmd(8'h03, 16'h3333);
        wait_writes("wrap_wait2", 50);
        check("wrap_addr_one", acc_log[acc_log.size()-1].addr, 1);

        // Ten-clock stall: request must hold steady and be accepted once.
        man_ready = 1'b0;
        cmd(8'h03, 16'h07E0);
        ticks(2);
        check("stall_we_up", bus.o_fb_we, 1);
        a0 = bus.o_fb_addr;
        d0 = bus.o_fb_data;
        base = acc_log.size();
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            if (bus.o_fb_we === 1'b1 && bus.o_fb_addr === a0 && bus.o_fb_data === d0)
                stable++;
        end
        check("stall_stable_cycles", stable, 10);
        man_ready = 1'b1;
        ticks(4);
        man_ready = 1'b0;
        check("stall_one_accept", acc_log.size() - base, 1);
        check("stall_we_down", bus.o_fb_we, 0);

        // Six back-to-back pixels while stalled: the sixth is dropped.
        base = acc_log.size();
        for (int i = 0; i < 5; i++) cmd(8'h03, 16'hA000 + 16'(i));
        send(8'h03, 16'hA005);
        mstat[0] = 1'b1;
        ticks(3);
        check("ovf_status", status, mstat);
        check("ovf_none_accepted", acc_log.size() - base, 0);
        man_ready = 1'b1;
        wait_writes("ovf_drain", 200);
        ticks(10);
        check("ovf_five_written", acc_log.size() - base, 5);
        cmd(8'h1F, 16'h0000);
        ticks(3);
        check("clr_status", status, 0);

        // Randomized commands with random frame-buffer back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [7:0]  op;
            logic [15:0] pl;
            int          sel;
            sel = $urandom_range(0, 9);
            pl  = 16'($urandom);
            case (sel)
                0, 1: begin op = 8'h01; pl = 16'($urandom_range(0, 520)); end
                2:    begin op = 8'h02; pl = 16'($urandom_range(0, 300)); end
                3, 4, 5: op = 8'h03;
                6:    op = 8'h10;
                7:    op = 8'h11;
                8:    op = 8'h1F;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h1F})
                        op = 8'($urandom_range(0, 255));
                end
            endcase
            cmd(op, pl);
            ticks(3);
            if (op == 8'h03) wait_writes("rnd_write_wait", 200);
            check_regs("rnd");
        end
        rand_mode = 1'b0;

        // Reset in the middle of a stalled write with commands still queued.
        man_ready = 1'b0;
        ticks(2);
        send(8'h03, 16'h5A5A);
        ticks(3);
        check("rstw_we_up", bus.o_fb_we, 1);
        send(8'h10, 16'h0077);
        send(8'h11, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_we", bus.o_fb_we, 0);
        check("rstw_addr", bus.o_fb_addr, 0);
        check("rstw_data", bus.o_fb_data, 0);
        check("rstw_bl", bl, 0);
        check("rstw_disp", disp, 0);
        check("rstw_status", status, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        man_ready = 1'b1;
        base = acc_log.size();
        ticks(10);
        check("rstw_no_accept", acc_log.size() - base, 0);
        check_regs("rstw_fifo_empty");
        cmd(8'h03, 16'hBEEF);
        wait_writes("rstw_write_wait", 50);
        check("rstw_cursor_origin", acc_log[acc_log.size()-1].addr, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
